urng_lzd_seg: RTL and testbench
===============================

Name: urng_lzd_seg

Overview:
- Pipelined leading-zero detection stage that sits directly upstream of the segment masking stage in the ICDF Gaussian generator datapath.
- Takes a 64-bit uniform random word and, 2 cycles later, produces three outputs together:
  - the 6-bit leading-one position (`zero_pos`);
  - the 15-bit tail segment `urng[17:3]`;
  - the enable (`en_mask`) that qualifies the masking stage.
- Also keeps a saturating count of words with no '1' in the detection field, for RNG health monitoring.

Parameters:
- LZ_MSB, 63, top bit of the leading-zero search field.
- LZ_LSB, 18, bottom bit of the search field; field width = LZ_MSB-LZ_LSB+1 = 46.
- CNT_W, 16, width of the saturating all-zero event counter.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
- urng_vld  input  1  urng_in is valid this cycle.
- urng_in  input  64  uniform random word.
- hold  input  1  freezes the whole pipeline (all registers keep their value).
- cnt_clr  input  1  synchronous clear of zero_cnt.
- en_mask  output  1  zero_pos and urng_seg3 are valid; drives the masking stage enable.
- zero_pos  output  6  bit index (63..18) of the most significant '1' in urng_in[63:18]; 6'd0 if the field is all zero.
- urng_seg3  output  15  urng_in[17:3] of the same word, aligned with zero_pos.
- all_zero  output  1  the word currently presented had no '1' in [63:18]; qualified by en_mask.
- zero_cnt  output  CNT_W  count of valid all-zero words, saturating.

Behaviour:
- Reset (rst=0, asynchronous): all pipeline registers clear to 0; en_mask=0, zero_pos=0, urng_seg3=0, all_zero=0, zero_cnt=0. Values are held at 0 until the first rising edge after rst returns high.
- Pipeline: 2 register stages; latency exactly 2 cycles from urng_vld to en_mask when hold=0. Throughput is 1 word per cycle with no bubbles.
- Stage 1 (capture + group detect):
  - Split the field into groups G5..G0, 8 bits each from bit 63 downward; G0 = [23:18] is 6 bits wide.
  - Per group, register: any-one flag, 3-bit local index of the group's most significant '1', and urng_in[17:3].
  - Register valid1 = urng_vld.
- Stage 2 (priority select):
  - Pick the highest group with any-one set.
  - zero_pos = group base + local index. Bases: G5=56, G4=48, G3=40, G2=32, G1=24, G0=18.
  - If no group has a '1': zero_pos=6'd0 and all_zero=1.
  - Register en_mask = valid1 and pass urng_seg3 through.
- Example results: urng_in[63]=1 → zero_pos=63. Only bit 61 set → 61. Only bit 46 set → 46. Only bit 18 set → 18.
- Non-valid slots: when valid is 0, the data registers still load (no gating required). en_mask=0 marks those outputs don't-care.
- hold=1: no register (valid or data) changes; urng_vld and urng_in are ignored that cycle. Outputs stay stable while held. On release, the pipeline resumes with no loss or duplication of in-flight words.
- zero_cnt:
  - Increments by 1 on each clock edge where stage 2 is loading a valid all-zero word (valid1=1, no group set, hold=0).
  - Saturates at 2^CNT_W-1; it never wraps.
  - cnt_clr=1 sets it to 0 and takes priority over a simultaneous increment.
  - hold does not block cnt_clr.
- Reset mid-operation: in-flight words are discarded, and no en_mask pulse is produced for them after reset releases.
- The output range of zero_pos (0, 18..63) is a superset of what the masking stage decodes. Values it does not decode select its all-ones mask; this stage does no clamping.

Test Plan:
- Reset then a single word 64'h8000_0000_0000_0000 with urng_vld for 1 cycle → 2 cycles later en_mask=1 for exactly 1 cycle, zero_pos=63, urng_seg3=0, all_zero=0.
- Back-to-back words with bit 61, bit 46, bit 18 set (and urng_in[17:3]=15'h5A5A, 15'h0001, 15'h7FFF respectively) → on consecutive cycles zero_pos=61/46/18 with the matching urng_seg3, and en_mask held high for 3 cycles.
- Word 64'h0000_0000_0003_FFF8 (field all zero) → zero_pos=0, all_zero=1, urng_seg3=15'h7FFF, zero_cnt=1. Repeat with cnt_clr asserted on the same edge as the increment → zero_cnt=0.
- Stream 4 valid words, assert hold for 3 cycles mid-stream → outputs frozen during hold; all 4 words emerge in order, each exactly once.
- Force the counter to 16'hFFFE, feed 3 all-zero words → zero_cnt=16'hFFFF and it stays there.
- Pull rst low asynchronously between edges with 2 words in flight → outputs go to 0 immediately; no en_mask pulse appears after rst returns high.

Source files
------------

// File: rtl/urng_lzd_seg.sv
// urng_lzd_seg: two-stage leading-one detector over urng_in[63:18] with aligned tail segment and all-zero health counter
module urng_lzd_seg #(
    parameter int LZ_MSB = 63,
    parameter int LZ_LSB = 18,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             urng_vld,
    input  logic [63:0]      urng_in,
    input  logic             hold,
    input  logic             cnt_clr,
    output logic             en_mask,
    output logic [5:0]       zero_pos,
    output logic [14:0]      urng_seg3,
    output logic             all_zero,
    output logic [CNT_W-1:0] zero_cnt
);
    localparam int FW  = LZ_MSB - LZ_LSB + 1;
    localparam int NG  = (FW + 7) / 8;
    localparam int PAD = NG * 8 - FW;

    logic [NG*8-1:0]     fld;
    logic [NG-1:0]       any_d, any1;
    logic [NG-1:0][2:0]  idx_d, idx1;
    logic [14:0]         seg1;
    logic                v1;
    logic [5:0]          pos_d;
    logic                unused_bits;

    function automatic logic [2:0] msb8(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    // The lowest group is short; padding its bottom keeps every other group byte-aligned from the top
    assign fld = {urng_in[LZ_MSB:LZ_LSB], {PAD{1'b0}}};
    assign unused_bits = ^urng_in[2:0];

    // Per-group any-one flag and local leading-one index (lowest group indexed from its real LSB)
    always_comb begin
        any_d = '0;
        idx_d = '0;
        for (int g = 0; g < NG; g++) begin
            any_d[g] = |fld[8*g +: 8];
            idx_d[g] = msb8(g == 0 ? fld[7:0] >> PAD : fld[8*g +: 8]);
        end
    end

    // Highest flagged group wins; its base plus local index gives the absolute bit position
    always_comb begin
        pos_d = '0;
        for (int g = 0; g < NG; g++)
            if (any1[g]) pos_d = 6'(LZ_LSB + (g == 0 ? 0 : 8 * g - PAD)) + idx1[g];
    end

    // Stage 1: capture group detection and tail segment; hold freezes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1   <= 1'b0;
            any1 <= '0;
            idx1 <= '0;
            seg1 <= '0;
        end else if (!hold) begin
            v1   <= urng_vld;
            any1 <= any_d;
            idx1 <= idx_d;
            seg1 <= urng_in[17:3];
        end
    end

    // Stage 2: register selected position with its aligned segment and valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_mask   <= 1'b0;
            zero_pos  <= '0;
            urng_seg3 <= '0;
            all_zero  <= 1'b0;
        end else if (!hold) begin
            en_mask   <= v1;
            zero_pos  <= pos_d;
            urng_seg3 <= seg1;
            all_zero  <= ~|any1;
        end
    end

    // Saturating count of valid all-zero words; clear wins and is not blocked by hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            zero_cnt <= '0;
        else if (cnt_clr)
            zero_cnt <= '0;
        else if (!hold && v1 && ~|any1 && ~&zero_cnt)
            zero_cnt <= zero_cnt + 1'b1;
    end
endmodule

// File: tb/tb_urng_lzd_seg.sv
// tb_urng_lzd_seg: directed scoreboard bench for the leading-one detection stage
module tb_urng_lzd_seg;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        urng_vld = 1'b0;
    logic [63:0] urng_in = '0;
    logic        hold = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        en_mask;
    logic [5:0]  zero_pos;
    logic [14:0] urng_seg3;
    logic        all_zero;
    logic [15:0] zero_cnt;
    logic [38:0] outs;
    logic [38:0] snap;
    logic        load_q = 1'b0;
    int          checks = 0;
    int          passes = 0;

    localparam logic [63:0] ZW = 64'h0000_0000_0003_FFF8;

    typedef struct packed {
        logic [5:0]  pos;
        logic [14:0] seg;
        logic        az;
    } exp_t;

    exp_t sb[$];

    urng_lzd_seg dut (
        .clk(clk), .rst(rst), .urng_vld(urng_vld), .urng_in(urng_in),
        .hold(hold), .cnt_clr(cnt_clr), .en_mask(en_mask), .zero_pos(zero_pos),
        .urng_seg3(urng_seg3), .all_zero(all_zero), .zero_cnt(zero_cnt)
    );

    assign outs = {en_mask, zero_pos, urng_seg3, all_zero, zero_cnt};

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [63:0] w);
        exp_t r;
        r.pos = '0;
        r.az  = 1'b1;
        r.seg = w[17:3];
        for (int b = 18; b <= 63; b++)
            if (w[b]) begin
                r.pos = 6'(b);
                r.az  = 1'b0;
            end
        return r;
    endfunction

    function automatic logic [63:0] mk(input int b, input logic [14:0] s);
        logic [63:0] one;
        one = 64'd1;
        return (one << b) | {46'b0, s, 3'b0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic vld, input logic [63:0] w, input logic h);
        @(posedge clk);
        #1;
        urng_vld = vld;
        urng_in  = w;
        hold     = h;
        cnt_clr  = 1'b0;
        if (vld && !h) sb.push_back(model(w));
    endtask

    // Only edges that actually advanced the pipeline can present a new word
    always @(posedge clk) load_q <= rst && !hold;

    always @(negedge clk) begin
        if (rst && load_q && en_mask) begin
            if (sb.size() == 0) chk("spurious_en_mask", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("zero_pos", zero_pos, e.pos);
                chk("urng_seg3", urng_seg3, e.seg);
                chk("all_zero", all_zero, e.az);
            end
        end
    end

    initial begin
        #12;
        chk("reset_outs", outs, 0);
        #5 rst = 1'b1;

        drive(1, 64'h8000_0000_0000_0000, 0);
        drive(0, 0, 0);
        chk("t1_en_early", en_mask, 0);
        drive(0, 0, 0);
        chk("t1_en", en_mask, 1);
        drive(0, 0, 0);
        chk("t1_en_once", en_mask, 0);

        drive(1, mk(61, 15'h5A5A), 0);
        drive(1, mk(46, 15'h0001), 0);
        drive(1, mk(18, 15'h7FFF), 0);
        chk("t2_en0", en_mask, 1);
        drive(0, 0, 0);
        chk("t2_en1", en_mask, 1);
        drive(0, 0, 0);
        chk("t2_en2", en_mask, 1);
        drive(0, 0, 0);
        chk("t2_en_end", en_mask, 0);

        drive(1, ZW, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("t3_cnt_inc", zero_cnt, 1);
        drive(1, ZW, 0);
        drive(0, 0, 0);
        cnt_clr = 1'b1;
        drive(0, 0, 0);
        chk("t3_cnt_clr_wins", zero_cnt, 0);

        drive(1, ZW, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("t3_cnt_again", zero_cnt, 1);
        drive(0, 0, 1);
        cnt_clr = 1'b1;
        drive(0, 0, 0);
        chk("t3_clr_under_hold", zero_cnt, 0);

        drive(1, mk(50, 15'h0011), 0);
        drive(1, mk(33, 15'h0022), 0);
        drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        snap = outs;
        chk("hold_snap_en", en_mask, 1);
        drive(1, 64'h1234_5678_9ABC_DEF0, 1);
        chk("hold_frozen1", outs, snap);
        drive(1, 64'h0F0F_0F0F_0F0F_0F0F, 1);
        chk("hold_frozen2", outs, snap);
        drive(1, mk(24, 15'h0033), 0);
        chk("hold_frozen3", outs, snap);
        drive(1, mk(20, 15'h0044), 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0);
        chk("hold_drained", sb.size(), 0);

        for (int i = 0; i < 65534; i++) drive(1, ZW, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("sat_fffe", zero_cnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) drive(1, ZW, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("sat_ffff", zero_cnt, 16'hFFFF);

        for (int i = 0; i < 12; i++)
            drive(1, {$urandom, $urandom} >> $urandom_range(0, 50), 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("sat_stays", zero_cnt, 16'hFFFF);

        drive(1, mk(40, 15'h0101), 0);
        drive(1, mk(30, 15'h0202), 0);
        drive(0, 0, 0);
        #1;
        chk("rst_inflight_en", en_mask, 1);
        rst = 1'b0;
        sb.delete();
        #1;
        chk("rst_async_outs", outs, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0);
            chk("rst_no_pulse", en_mask, 0);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) drive(0, 0, 0);
        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
